// File: rtl/fxp_add_rr_sched.sv
// Round-robin shared saturating Q(INT_W.FRAC_W) adder; accept->rsp_valid in 2 clk, 1 result/clk.
// Backpressure: rsp_ready low stalls S2, then S1; req_ready is zero whenever S1 cannot advance.
module fxp_add_rr_sched #(
  parameter int NREQ   = 4,
  parameter int INT_W  = 4,
  parameter int FRAC_W = 4,
  parameter int IDW    = 2,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ*(INT_W+FRAC_W)-1:0]   req_a,
  input  logic [NREQ*(INT_W+FRAC_W)-1:0]   req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [IDW-1:0]                   rsp_id,
  output logic [INT_W+FRAC_W-1:0]          rsp_sum,
  output logic                             rsp_ovf,
  output logic                             busy,
  output logic [CNT_W-1:0]                 ovf_cnt,
  output logic [CNT_W-1:0]                 xfer_cnt
);
  localparam int W = INT_W + FRAC_W;
  localparam logic [IDW:0] NREQ_L = (IDW+1)'(NREQ);

  logic           s1_v, s2_v, s2_ovf;
  logic [W-1:0]   s1_a, s1_b, s2_sum;
  logic [IDW-1:0] s1_id, s2_id, rr_ptr, sel_id, nxt_ptr;
  logic           adv1, adv2, found, acc;
  logic [NREQ-1:0] rot;
  logic [IDW:0]   ofs, wsum, np;
  logic [W:0]     sum_x;
  logic [W-1:0]   sum_sat;
  logic           ovf_x;

  assign adv2 = !s2_v || rsp_ready;
  assign adv1 = !s1_v || adv2;

  // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> rr_ptr);
    found = 1'b0;
    ofs   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        ofs   = (IDW+1)'(k);
      end
    end
    wsum = {1'b0, rr_ptr} + ofs;
    if (wsum >= NREQ_L) wsum = wsum - NREQ_L;
    sel_id = wsum[IDW-1:0];
    np = {1'b0, sel_id} + (IDW+1)'(1);
    if (np >= NREQ_L) np = '0;
    nxt_ptr = np[IDW-1:0];
  end

  assign acc       = adv1 && rst && found;
  assign req_ready = acc ? (NREQ'(1) << sel_id) : '0;

  always_comb begin
    sum_x   = {s1_a[W-1], s1_a} + {s1_b[W-1], s1_b};
    ovf_x   = sum_x[W] != sum_x[W-1];
    sum_sat = sum_x[W-1:0];
    if (ovf_x) sum_sat = sum_x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v     <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_v     <= 1'b0;
      s2_sum   <= '0;
      s2_ovf   <= 1'b0;
      s2_id    <= '0;
      rr_ptr   <= '0;
      ovf_cnt  <= '0;
      xfer_cnt <= '0;
    end else begin
      if (adv1) begin
        s1_v <= acc;
        if (acc) begin
          s1_a   <= req_a[sel_id*W +: W];
          s1_b   <= req_b[sel_id*W +: W];
          s1_id  <= sel_id;
          rr_ptr <= nxt_ptr;
        end
      end
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_sum <= sum_sat;
          s2_ovf <= ovf_x;
          s2_id  <= s1_id;
        end
      end
      if (s2_v && rsp_ready) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
        if (s2_ovf && (ovf_cnt != {CNT_W{1'b1}})) ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = s2_v;
  assign rsp_id    = s2_id;
  assign rsp_sum   = s2_sum;
  assign rsp_ovf   = s2_ovf;
  assign busy      = s1_v || s2_v;
endmodule

// File: tb/tb_fxp_add_rr_sched.sv
// Bench for fxp_add_rr_sched: queue-based reference model checked every cycle, plus directed cases.
module tb_fxp_add_rr_sched;
  localparam int NREQ = 4, INT_W = 4, FRAC_W = 4, IDW = 2, CNT_W = 8, W = 8;

  logic                 clk = 1'b0, rst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0, req_ready;
  logic [NREQ*W-1:0]    req_a = '0, req_b = '0;
  logic                 rsp_valid, rsp_ready = 1'b0, rsp_ovf, busy;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_sum;
  logic [CNT_W-1:0]     ovf_cnt, xfer_cnt;

  always #5 clk = ~clk;

  fxp_add_rr_sched #(.NREQ(NREQ), .INT_W(INT_W), .FRAC_W(FRAC_W), .IDW(IDW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf), .busy(busy),
    .ovf_cnt(ovf_cnt), .xfer_cnt(xfer_cnt));

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           ovf;
  } item_t;

  int total = 0, bad = 0;
  item_t q[$];
  logic [IDW-1:0] id_log[$];
  int t_log[$];
  int p = 0, m_xfer = 0, m_ovf = 0, cyc = 0;
  bit just_acc = 0, rand_en = 0;
  int vld_pct = 70, rdy_pct = 70;
  logic [NREQ-1:0] last_acc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Saturating add computed on plain integers.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic o);
    int x;
    x = $signed(a) + $signed(b);
    if (x > 127)       begin s = 8'h7F; o = 1'b1; end
    else if (x < -128) begin s = 8'h80; o = 1'b1; end
    else               begin s = x[7:0]; o = 1'b0; end
  endfunction

  // Model: in-flight results as a queue of at most 2; head is visible unless it was accepted on the last edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] g;
    bit ev, ca;
    int sel;
    item_t it;
    cyc++;
    if (!rst) begin
      q.delete(); p = 0; just_acc = 0; m_xfer = 0; m_ovf = 0; last_acc = '0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_outs", {rsp_id, rsp_sum, rsp_ovf}, 0);
      chk("rst_cnts", {ovf_cnt, xfer_cnt}, 0);
    end else begin
      ev = (q.size() > 0) && !(q.size() == 1 && just_acc);
      ca = (q.size() < 2) || rsp_ready;
      g = '0; sel = -1;
      if (ca)
        for (int k = 0; k < NREQ; k++)
          if (sel < 0 && req_valid[(p+k)%NREQ]) sel = (p+k) % NREQ;
      if (sel >= 0) g[sel] = 1'b1;
      chk("req_ready", req_ready, g);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_sum", rsp_sum, q[0].sum);
        chk("rsp_ovf", rsp_ovf, q[0].ovf);
      end
      chk("busy", busy, q.size() > 0);
      chk("xfer_cnt", xfer_cnt, m_xfer % 256);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      if (ev && rsp_ready) begin
        it = q.pop_front();
        m_xfer++;
        if (it.ovf && m_ovf < 255) m_ovf++;
        id_log.push_back(it.id);
        t_log.push_back(cyc);
      end
      just_acc = (sel >= 0);
      if (sel >= 0) begin
        ref_add(req_a[sel*W +: W], req_b[sel*W +: W], it.sum, it.ovf);
        it.id = IDW'(sel);
        q.push_back(it);
        p = (sel + 1) % NREQ;
      end
      last_acc = g;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (rand_en) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || last_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < vld_pct);
          req_a[i*W +: W] = 8'($urandom);
          req_b[i*W +: W] = 8'($urandom);
        end
      rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    step();
    rst = 1'b1;
  endtask

  task automatic one_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic eo);
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_valid[i] = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid[i] = 1'b0;
    chk("op_lat_early", rsp_valid, 0);
    step();
    chk("op_valid", rsp_valid, 1);
    chk("op_sum", rsp_sum, es);
    chk("op_ovf", rsp_ovf, eo);
    chk("op_id", rsp_id, i);
    step();
  endtask

  initial begin
    logic [W-1:0] ms; logic mo; bit found;
    ref_add(8'h18, 8'h28, ms, mo); chk("model_pin_add", {mo, ms}, {1'b0, 8'h40});
    ref_add(8'h90, 8'hE0, ms, mo); chk("model_pin_min", {mo, ms}, {1'b1, 8'h80});
    #1;
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_cnts", {ovf_cnt, xfer_cnt}, 0);
    step(); step();
    rst = 1'b1;

    one_op(0, 8'h18, 8'h28, 8'h40, 1'b0);
    one_op(0, 8'h70, 8'h20, 8'h7F, 1'b1);
    one_op(0, 8'h90, 8'hE0, 8'h80, 1'b1);
    chk("sat_ovf_cnt", ovf_cnt, 2);
    chk("sat_xfer_cnt", xfer_cnt, 3);

    do_reset();
    id_log.delete(); t_log.delete(); rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 8'(16*i + 1); req_b[i*W +: W] = 8'(i);
    end
    req_valid = '1;
    repeat (8) step();
    req_valid = '0;
    repeat (4) step();
    chk("fair_count", id_log.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < id_log.size()) begin
        chk("fair_id", id_log[k], k % 4);
        if (k > 0) chk("fair_b2b", t_log[k] - t_log[k-1], 1);
      end

    do_reset();
    id_log.delete(); rsp_ready = 1'b0; req_valid = '1;
    repeat (5) step();
    chk("bp_busy", busy, 1);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_rsp_id", rsp_id, 0);
    chk("bp_rsp_sum", rsp_sum, 8'h01);
    chk("bp_held", q.size(), 2);
    rsp_ready = 1'b1; req_valid = '0;
    repeat (4) step();
    chk("bp_drained", id_log.size(), 2);
    if (id_log.size() == 2) begin
      chk("bp_order0", id_log[0], 0);
      chk("bp_order1", id_log[1], 1);
    end
    chk("bp_idle", busy, 0);

    do_reset();
    rand_en = 1;
    repeat (1500) step();
    rdy_pct = 20; found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      step();
      if (q.size() == 2) found = 1;
    end
    chk("mid_full_found", found, 1);
    chk("mid_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_cnts", {ovf_cnt, xfer_cnt}, 0);
    step();
    rst = 1'b1;
    chk("post_rst_valid0", rsp_valid, 0);
    step();
    chk("post_rst_valid1", rsp_valid, 0);
    rdy_pct = 70;
    repeat (1500) step();
    rand_en = 0; req_valid = '0; rsp_ready = 1'b1;
    repeat (4) step();
    chk("rand_idle", busy, 0);

    do_reset();
    rsp_ready = 1'b1;
    req_a[0 +: W] = 8'h70; req_b[0 +: W] = 8'h70; req_valid = 4'b0001;
    for (int n = 0; n < 400 && m_xfer < 256; n++) step();
    chk("cnt_reached", m_xfer, 256);
    chk("cnt_xfer_wrap", xfer_cnt, 0);
    chk("cnt_ovf_hold", ovf_cnt, 255);
    step();
    chk("cnt_xfer_next", xfer_cnt, 1);
    chk("cnt_ovf_hold2", ovf_cnt, 255);
    req_valid = '0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
